// File: rtl/exe_issue_ctrl.sv
// exe_issue_ctrl: in-order issue queue in front of the scalar execute scoreboard.
// Decoded instructions are buffered in a small circular queue. The head issues when
// the scoreboard reports its latency class ready. The matching scoreboard set line
// pulses in the same cycle. Blocked-head cycles are counted for performance monitoring.
module exe_issue_ctrl #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned DATA_W      = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,

  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [2:0]        instr_unit_i,
  input  logic [DATA_W-1:0] instr_data_i,

  input  logic              ready_1cycle_i,
  input  logic              ready_mul_32_i,
  input  logic              ready_mul_64_i,
  input  logic              ready_div_32_i,
  input  logic              div_unit_sel_i,
  input  logic              ready_div_unit_i,

  output logic              set_mul_32_o,
  output logic              set_mul_64_o,
  output logic              set_div_32_o,
  output logic              set_div_64_o,

  output logic              issue_valid_o,
  output logic [2:0]        issue_unit_o,
  output logic [DATA_W-1:0] issue_data_o,
  output logic              issue_div_unit_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [2:0] UnitAlu   = 3'd0;
  localparam logic [2:0] UnitMul32 = 3'd1;
  localparam logic [2:0] UnitMul64 = 3'd2;
  localparam logic [2:0] UnitDiv32 = 3'd3;
  localparam logic [2:0] UnitDiv64 = 3'd4;

  localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_DEPTH);
  localparam logic [15:0]     StallMax = 16'hFFFF;

  // Queue storage; never read while empty, so it needs no reset.
  logic [DATA_W-1:0] data_q [QUEUE_DEPTH];
  logic [2:0]        unit_q [QUEUE_DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     stall_q, stall_d;

  logic              push;
  logic              issue;
  logic              head_valid;
  logic [2:0]        head_unit;
  logic [DATA_W-1:0] head_data;
  logic              can_go;
  logic              head_is_div;
  logic [2:0]        unit_norm;

  // Classes 5-7 are folded onto ALU before they enter the queue.
  always_comb begin
    unit_norm = (instr_unit_i > UnitDiv64) ? UnitAlu : instr_unit_i;
  end

  // Ready depends on registered occupancy only.
  always_comb begin
    instr_ready_o = (count_q != CntFull);
    push          = instr_valid_i & instr_ready_o & ~flush_i;
  end

  // Head view of the queue.
  always_comb begin
    head_valid = (count_q != '0);
    head_unit  = unit_q[rd_ptr_q];
    head_data  = data_q[rd_ptr_q];
  end

  // Issue condition per latency class of the head entry.
  always_comb begin
    can_go      = 1'b0;
    head_is_div = 1'b0;
    case (head_unit)
      UnitAlu:   can_go = ready_1cycle_i;
      UnitMul32: can_go = ready_mul_32_i;
      UnitMul64: can_go = ready_mul_64_i;
      UnitDiv32: begin
        can_go      = ready_div_32_i & ready_div_unit_i;
        head_is_div = 1'b1;
      end
      UnitDiv64: begin
        can_go      = ready_div_unit_i;
        head_is_div = 1'b1;
      end
      default:   can_go = ready_1cycle_i;
    endcase
    issue = head_valid & can_go & ~flush_i;
  end

  // Issue outputs and scoreboard set pulses; zero whenever nothing issues.
  always_comb begin
    issue_valid_o    = issue;
    issue_unit_o     = issue ? head_unit : 3'd0;
    issue_data_o     = issue ? head_data : '0;
    issue_div_unit_o = issue & head_is_div & div_unit_sel_i;
    set_mul_32_o     = issue & (head_unit == UnitMul32);
    set_mul_64_o     = issue & (head_unit == UnitMul64);
    set_div_32_o     = issue & (head_unit == UnitDiv32);
    set_div_64_o     = issue & (head_unit == UnitDiv64);
    stall_cnt_o      = stall_q;
  end

  // Next-state for pointers, occupancy and the stall counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, issue})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Flush empties the queue but keeps the performance counter.
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    if (head_valid && !can_go && !flush_i && (stall_q != StallMax)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Payload and class write on push.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= instr_data_i;
      unit_q[wr_ptr_q] <= unit_norm;
    end
  end

  // The scoreboard relies on never seeing two inserts in one cycle.
  a_set_onehot0 : assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0({set_mul_32_o, set_mul_64_o, set_div_32_o, set_div_64_o}));

  // Occupancy never exceeds the queue depth.
  a_count_range : assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_q <= CntFull);

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl with an expected-issue scoreboard.
module tb_exe_issue_ctrl;

  localparam int unsigned DW = 64;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          flush;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_unit;
  logic [DW-1:0] instr_data;
  logic          rdy_alu, rdy_m32, rdy_m64, rdy_d32, div_sel, rdy_du;
  logic          set_m32, set_m64, set_d32, set_d64;
  logic          issue_valid;
  logic [2:0]    issue_unit;
  logic [DW-1:0] issue_data;
  logic          issue_div_unit;
  logic [15:0]   stall_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_stall   = 0;

  typedef struct packed {
    logic [2:0]    unit;
    logic [DW-1:0] data;
  } ent_t;

  ent_t sb[$];

  always #5 clk_i = ~clk_i;

  exe_issue_ctrl #(
    .QUEUE_DEPTH(2),
    .DATA_W     (DW)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .flush_i         (flush),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .instr_unit_i    (instr_unit),
    .instr_data_i    (instr_data),
    .ready_1cycle_i  (rdy_alu),
    .ready_mul_32_i  (rdy_m32),
    .ready_mul_64_i  (rdy_m64),
    .ready_div_32_i  (rdy_d32),
    .div_unit_sel_i  (div_sel),
    .ready_div_unit_i(rdy_du),
    .set_mul_32_o    (set_m32),
    .set_mul_64_o    (set_m64),
    .set_div_32_o    (set_d32),
    .set_div_64_o    (set_d64),
    .issue_valid_o   (issue_valid),
    .issue_unit_o    (issue_unit),
    .issue_data_o    (issue_data),
    .issue_div_unit_o(issue_div_unit),
    .stall_cnt_o     (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_readies(input logic v);
    rdy_alu = v; rdy_m32 = v; rdy_m64 = v; rdy_d32 = v; rdy_du = v;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    instr_unit  = 3'd0;
    instr_data  = '0;
  endtask

  // Drive an instruction without predicting acceptance.
  task automatic drive(input logic [2:0] u, input logic [DW-1:0] d);
    instr_valid = 1'b1;
    instr_unit  = u;
    instr_data  = d;
  endtask

  // Drive an instruction that the queue is expected to accept.
  task automatic offer(input logic [2:0] u, input logic [DW-1:0] d);
    ent_t e;
    drive(u, d);
    e.unit = (u > 3'd4) ? 3'd0 : u;
    e.data = d;
    sb.push_back(e);
  endtask

  // Compare the combinational issue side against the scoreboard head.
  task automatic observe(input string tag, input logic exp_issue);
    ent_t       e;
    logic [3:0] exp_set;
    logic       exp_div;
    check({tag, "_issue_valid"}, 64'(issue_valid), 64'(exp_issue));
    if (exp_issue) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s_sb_underflow: observed issue expected none queued", tag);
      end else begin
        e       = sb.pop_front();
        exp_set = {e.unit == 3'd1, e.unit == 3'd2, e.unit == 3'd3, e.unit == 3'd4};
        exp_div = (e.unit == 3'd3 || e.unit == 3'd4) ? div_sel : 1'b0;
        check({tag, "_unit"}, 64'(issue_unit), 64'(e.unit));
        check({tag, "_data"}, issue_data, e.data);
        check({tag, "_set"}, 64'({set_m32, set_m64, set_d32, set_d64}), 64'(exp_set));
        check({tag, "_div_unit"}, 64'(issue_div_unit), 64'(exp_div));
      end
    end else begin
      check({tag, "_set_idle"}, 64'({set_m32, set_m64, set_d32, set_d64}), 64'(0));
      check({tag, "_data_idle"}, issue_data, 64'(0));
      check({tag, "_div_idle"}, 64'(issue_div_unit), 64'(0));
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    flush  = 1'b0;
    div_sel = 1'b0;
    set_readies(1'b0);
    idle();

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ready", 64'(instr_ready), 64'(1));
    check("rst_stall", 64'(stall_cnt), 64'(0));
    check("rst_unit", 64'(issue_unit), 64'(0));
    observe("rst", 1'b0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // ALU with 1-cycle latency
    rdy_alu = 1'b1;
    offer(3'd0, 64'h11);
    #1; check("t1_ready0", 64'(instr_ready), 64'(1)); observe("t1_c0", 1'b0);
    step(); idle();
    #1; observe("t1_c1", 1'b1); check("t1_ready1", 64'(instr_ready), 64'(1));
    step();

    // MUL64 blocked for three cycles
    offer(3'd2, 64'h22);
    #1; observe("t2_c0", 1'b0);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      #1; observe("t2_blk", 1'b0);
      step(); exp_stall++;
    end
    rdy_m64 = 1'b1;
    #1; check("t2_stall", 64'(stall_cnt), 64'(exp_stall)); observe("t2_go", 1'b1);
    step();
    #1; observe("t2_after", 1'b0); check("t2_stall_hold", 64'(stall_cnt), 64'(exp_stall));

    // DIV32 on unit 1, DIV64 behind it waits for a free divider
    rdy_d32 = 1'b1; rdy_du = 1'b1; div_sel = 1'b1;
    offer(3'd3, 64'h33);
    #1; observe("t3_c0", 1'b0);
    step();
    offer(3'd4, 64'h44);
    #1; observe("t3_div32", 1'b1);
    step(); idle(); rdy_du = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; observe("t3_div64_blk", 1'b0);
      step(); exp_stall++;
    end
    rdy_du = 1'b1; div_sel = 1'b0;
    #1; check("t3_stall", 64'(stall_cnt), 64'(exp_stall)); observe("t3_div64", 1'b1);
    step();

    // Fill to full with everything blocked
    set_readies(1'b0);
    offer(3'd0, 64'h55);
    #1; check("t4_ready_a", 64'(instr_ready), 64'(1)); observe("t4_a", 1'b0);
    step();
    offer(3'd1, 64'h66);
    #1; check("t4_ready_b", 64'(instr_ready), 64'(1)); observe("t4_b", 1'b0);
    step(); exp_stall++;
    drive(3'd3, 64'h77);
    #1; check("t4_ready_full", 64'(instr_ready), 64'(0)); observe("t4_c", 1'b0);
    step(); exp_stall++; idle(); set_readies(1'b1);
    #1; check("t4_ready_d", 64'(instr_ready), 64'(0)); observe("t4_d", 1'b1);
    step();
    #1; check("t4_ready_e", 64'(instr_ready), 64'(1)); observe("t4_e", 1'b1);
    step();
    #1; observe("t4_f", 1'b0); check("t4_stall", 64'(stall_cnt), 64'(exp_stall));

    // Flush with a full queue
    set_readies(1'b0);
    offer(3'd0, 64'h88);
    #1; observe("t5_a", 1'b0);
    step();
    offer(3'd1, 64'h99);
    #1; observe("t5_b", 1'b0);
    step(); exp_stall++;
    flush = 1'b1; set_readies(1'b1); drive(3'd0, 64'hAA);
    #1; observe("t5_flush", 1'b0); check("t5_ready_full", 64'(instr_ready), 64'(0));
    sb.delete();
    step(); flush = 1'b0; idle();
    #1; check("t5_ready_empty", 64'(instr_ready), 64'(1)); observe("t5_d", 1'b0);
    step();
    #1; observe("t5_e", 1'b0); check("t5_stall", 64'(stall_cnt), 64'(exp_stall));

    // Class 6 issues as ALU
    set_readies(1'b0); rdy_alu = 1'b1;
    offer(3'd6, 64'hBB);
    #1; observe("t6_a", 1'b0);
    step(); idle();
    #1; observe("t6_b", 1'b1);
    step();

    // Back-to-back issue at one per cycle
    set_readies(1'b1);
    offer(3'd0, 64'hC0);
    #1; observe("t7_a", 1'b0);
    step();
    offer(3'd1, 64'hC1);
    #1; observe("t7_b", 1'b1); check("t7_ready_b", 64'(instr_ready), 64'(1));
    step();
    offer(3'd2, 64'hC2);
    #1; observe("t7_c", 1'b1); check("t7_ready_c", 64'(instr_ready), 64'(1));
    step(); idle();
    #1; observe("t7_d", 1'b1);
    step();
    #1; observe("t7_e", 1'b0);

    // Reset mid-operation discards queued entries
    set_readies(1'b0);
    offer(3'd0, 64'hD0);
    step();
    offer(3'd0, 64'hD1);
    step(); idle();
    rstn_i = 1'b0;
    #1; check("t8_rst_ready", 64'(instr_ready), 64'(1)); check("t8_rst_stall", 64'(stall_cnt), 64'(0));
    observe("t8_rst", 1'b0);
    sb.delete();
    step();
    #1; rstn_i = 1'b1; set_readies(1'b1);
    #1; observe("t8_post0", 1'b0);
    step();
    #1; observe("t8_post1", 1'b0); check("t8_stall", 64'(stall_cnt), 64'(0));

    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
